// File: rtl/ysyx_22040759_clint_arb.sv
// ysyx_22040759_clint_arb: round-robin two-port arbiter in front of the CLINT, strobed writes done as read-modify-write
`timescale 1ns/1ps
module ysyx_22040759_clint_arb #(
    parameter logic [31:0] ADDR_MTIMECMP = 32'h0200_4000,
    parameter logic [31:0] ADDR_MTIME    = 32'h0200_BFF8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic        m0_wen,
    input  logic [7:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [63:0] m0_wdata,
    output logic        m0_resp_valid,
    input  logic        m0_resp_ready,
    output logic [63:0] m0_rdata,
    output logic        m0_resp_err,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic        m1_wen,
    input  logic [7:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [63:0] m1_wdata,
    output logic        m1_resp_valid,
    input  logic        m1_resp_ready,
    output logic [63:0] m1_rdata,
    output logic        m1_resp_err,
    output logic        clint_wen,
    output logic [31:0] clint_addr,
    output logic [63:0] clint_wdata,
    input  logic [63:0] clint_rdata
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t state, state_nxt;
    logic        last_grant, id, wen, err;
    logic [7:0]  wstrb;
    logic [31:0] addr;
    logic [63:0] wdata, old_q, merged, rdata_v;
    logic        g0, g1, acc, mapped, resp_ready_sel, busy;
    logic [31:0] sel_addr;
    assign g0 = rst_n & (state == IDLE) & m0_valid & (!m1_valid | last_grant);
    assign g1 = rst_n & (state == IDLE) & m1_valid & (!m0_valid | !last_grant);
    assign acc = g0 | g1;
    assign sel_addr = g1 ? m1_addr : m0_addr;
    assign mapped = (sel_addr == ADDR_MTIMECMP) | (sel_addr == ADDR_MTIME);
    assign resp_ready_sel = id ? m1_resp_ready : m0_resp_ready;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = acc ? (mapped ? READ : RESP) : IDLE;
            READ:    state_nxt = wen ? WRITE : RESP;
            WRITE:   state_nxt = RESP;
            RESP:    state_nxt = resp_ready_sel ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id         <= 1'b0;
            wen        <= 1'b0;
            err        <= 1'b0;
            wstrb      <= '0;
            addr       <= '0;
            wdata      <= '0;
            old_q      <= '0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                last_grant <= g1;
                id         <= g1;
                wen        <= g1 ? m1_wen : m0_wen;
                wstrb      <= g1 ? m1_wstrb : m0_wstrb;
                addr       <= sel_addr;
                wdata      <= g1 ? m1_wdata : m0_wdata;
                err        <= !mapped;
                old_q      <= '0;
            end
            if (state == READ) old_q <= clint_rdata;
        end
    end
    for (genvar b = 0; b < 8; b++) begin : g_merge
        assign merged[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_q[8*b +: 8];
    end
    assign busy = (state == READ) | (state == WRITE);
    assign clint_wen = state == WRITE;
    assign clint_addr = busy ? addr : '0;
    assign clint_wdata = clint_wen ? merged : '0;
    assign m0_ready = g0;
    assign m1_ready = g1;
    assign m0_resp_valid = (state == RESP) & !id;
    assign m1_resp_valid = (state == RESP) & id;
    assign rdata_v = err ? '0 : old_q;
    assign m0_rdata = m0_resp_valid ? rdata_v : '0;
    assign m1_rdata = m1_resp_valid ? rdata_v : '0;
    assign m0_resp_err = m0_resp_valid & err;
    assign m1_resp_err = m1_resp_valid & err;
endmodule

// File: tb/tb_ysyx_22040759_clint_arb.sv
// tb_ysyx_22040759_clint_arb: table vectors, hand sequences and random traffic against a transaction-level model
`timescale 1ns/1ps
module tb_ysyx_22040759_clint_arb;
    localparam logic [31:0] CMP = 32'h0200_4000;
    localparam logic [31:0] MT  = 32'h0200_BFF8;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_valid = 0, m0_wen = 0, m0_resp_ready = 0;
    logic [7:0]  m0_wstrb = 0;
    logic [31:0] m0_addr = 0;
    logic [63:0] m0_wdata = 0;
    logic        m1_valid = 0, m1_wen = 0, m1_resp_ready = 0;
    logic [7:0]  m1_wstrb = 0;
    logic [31:0] m1_addr = 0;
    logic [63:0] m1_wdata = 0;
    logic        m0_ready, m0_resp_valid, m0_resp_err, m1_ready, m1_resp_valid, m1_resp_err;
    logic [63:0] m0_rdata, m1_rdata, clint_wdata, clint_rdata;
    logic        clint_wen;
    logic [31:0] clint_addr;
    logic [63:0] stub_cmp = 64'hC0C0, stub_time = 64'h7777;
    logic [63:0] m_cmp = 64'hC0C0, m_time = 64'h7777;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    ysyx_22040759_clint_arb dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wen(m0_wen), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_resp_valid(m0_resp_valid),
        .m0_resp_ready(m0_resp_ready), .m0_rdata(m0_rdata), .m0_resp_err(m0_resp_err),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wen(m1_wen), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_resp_valid(m1_resp_valid),
        .m1_resp_ready(m1_resp_ready), .m1_rdata(m1_rdata), .m1_resp_err(m1_resp_err),
        .clint_wen(clint_wen), .clint_addr(clint_addr), .clint_wdata(clint_wdata),
        .clint_rdata(clint_rdata)
    );

    // CLINT stand-in: two registers, combinational read, a distinctive value elsewhere
    assign clint_rdata = clint_addr == CMP ? stub_cmp : clint_addr == MT ? stub_time : 64'hDEAD_BEEF_DEAD_BEEF;
    always @(posedge clk) begin
        if (clint_wen && clint_addr == CMP) stub_cmp <= clint_wdata;
        if (clint_wen && clint_addr == MT) stub_time <= clint_wdata;
    end

    typedef struct {
        bit          p;
        bit          w;
        logic [7:0]  s;
        logic [31:0] a;
        logic [63:0] d;
        logic [63:0] rd;
        bit          er;
        int          lat;
        int          wc;
        logic [63:0] wd;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_req(input bit p, input bit v, input bit w, input logic [7:0] s,
                           input logic [31:0] a, input logic [63:0] d);
        if (p) begin
            m1_valid = v; m1_wen = w; m1_wstrb = s; m1_addr = a; m1_wdata = d;
        end else begin
            m0_valid = v; m0_wen = w; m0_wstrb = s; m0_addr = a; m0_wdata = d;
        end
    endtask

    // Transaction view: response = prior value (or 0 + err), register becomes byte-merged value
    function automatic void model(input bit w, input logic [7:0] s, input logic [31:0] a,
                                  input logic [63:0] d, output logic [63:0] rd, output bit er,
                                  output int lat, output int wc, output logic [63:0] wd);
        logic [63:0] cur, nv;
        if (a != CMP && a != MT) begin
            rd = 0; er = 1; lat = 1; wc = 0; wd = 0;
            return;
        end
        cur = (a == CMP) ? m_cmp : m_time;
        nv = cur;
        for (int b = 0; b < 8; b++) if (w && s[b]) nv[8*b +: 8] = d[8*b +: 8];
        rd = cur; er = 0; lat = w ? 3 : 2; wc = w ? 1 : 0; wd = nv;
        if (w && a == CMP) m_cmp = nv;
        if (w && a == MT) m_time = nv;
    endfunction

    task automatic run(input bit p, input bit w, input logic [7:0] s, input logic [31:0] a,
                       input logic [63:0] d, output logic [63:0] rd, output bit er,
                       output int lat, output int wc, output logic [63:0] wd, output bit wrong);
        int k;
        rd = 0; er = 0; lat = -1; wc = 0; wd = 0; wrong = 0; k = 0;
        @(negedge clk);
        set_req(p, 1'b1, w, s, a, d);
        #1;
        while (!(p ? m1_ready : m0_ready) && k < 20) begin
            @(negedge clk); #1; k++;
        end
        @(negedge clk);
        set_req(p, 1'b0, w, s, a, d);
        if (k == 20) return;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (clint_wen) begin wc++; wd = clint_wdata; end
            if (p ? m0_resp_valid : m1_resp_valid) wrong = 1;
            if (p ? m1_resp_valid : m0_resp_valid) begin
                lat = c;
                rd = p ? m1_rdata : m0_rdata;
                er = p ? m1_resp_err : m0_resp_err;
                break;
            end
            @(negedge clk);
        end
        if (p) m1_resp_ready = 1; else m0_resp_ready = 1;
        @(negedge clk);
        m0_resp_ready = 0; m1_resp_ready = 0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [63:0] rd, wd;
        bit er, wrong;
        int lat, wc;
        run(v.p, v.w, v.s, v.a, v.d, rd, er, lat, wc, wd, wrong);
        chk({tag, "_rdata"}, rd, v.rd);
        chk({tag, "_err"}, 64'(er), 64'(v.er));
        chk({tag, "_lat"}, 64'(lat), 64'(v.lat));
        chk({tag, "_wen_cycles"}, 64'(wc), 64'(v.wc));
        if (v.wc == 1) chk({tag, "_wdata"}, wd, v.wd);
        chk({tag, "_wrong_port"}, 64'(wrong), 64'd0);
    endtask

    initial begin
        logic [63:0] rd, wd;
        bit er;
        int lat, wc, n, r0, r1, cyc, k;
        bit g[4];
        vec_t v;
        tbl[0]  = '{1'b0, 1'b1, 8'hFF, CMP, 64'h1234, 64'hC0C0, 1'b0, 3, 1, 64'h1234};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, CMP, 64'h0, 64'h1234, 1'b0, 2, 0, 64'h0};
        tbl[2]  = '{1'b0, 1'b1, 8'hFF, CMP, 64'h1111_2222_3333_4444, 64'h1234, 1'b0, 3, 1, 64'h1111_2222_3333_4444};
        tbl[3]  = '{1'b1, 1'b1, 8'h0F, CMP, 64'hAAAA_AAAA_AAAA_AAAA, 64'h1111_2222_3333_4444, 1'b0, 3, 1, 64'h1111_2222_AAAA_AAAA};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, CMP, 64'h0, 64'h1111_2222_AAAA_AAAA, 1'b0, 2, 0, 64'h0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 32'h0200_0000, 64'h0, 64'h0, 1'b1, 1, 0, 64'h0};
        tbl[6]  = '{1'b1, 1'b1, 8'hFF, 32'h0200_4001, 64'h5, 64'h0, 1'b1, 1, 0, 64'h0};
        tbl[7]  = '{1'b0, 1'b1, 8'h00, MT, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7777, 1'b0, 3, 1, 64'h7777};
        tbl[8]  = '{1'b1, 1'b1, 8'h01, MT, 64'h55, 64'h7777, 1'b0, 3, 1, 64'h7755};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, MT, 64'h0, 64'h7755, 1'b0, 2, 0, 64'h0};
        tbl[10] = '{1'b1, 1'b0, 8'hFF, MT, 64'h99, 64'h7755, 1'b0, 2, 0, 64'h0};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_m0_ready", 64'(m0_ready), 0);
        chk("rst_resp_valid", 64'({m0_resp_valid, m1_resp_valid}), 0);
        chk("rst_clint", {31'd0, clint_wen, clint_addr}, 0);
        chk("rst_clint_wdata", clint_wdata, 0);
        rst_n = 1;

        // Tie: both requesters hold valid; grants must alternate starting with m0
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 8'h0, CMP, 64'h0);
        set_req(1'b1, 1'b1, 1'b0, 8'h0, MT, 64'h0);
        m0_resp_ready = 1; m1_resp_ready = 1;
        n = 0; r0 = 0; r1 = 0; cyc = 0;
        while (cyc < 40 && !(n == 4 && !m0_valid)) begin
            #1;
            if (n == 4) begin
                m0_valid = 0; m1_valid = 0;
            end else if (m0_ready && m1_ready) begin
                chk("tie_both_ready", 1, 0);
            end else if (m0_ready || m1_ready) begin
                g[n] = m1_ready; n++;
            end
            if (m0_resp_valid) begin r0++; chk("tie_rdata0", m0_rdata, m_cmp); end
            if (m1_resp_valid) begin r1++; chk("tie_rdata1", m1_rdata, m_time); end
            @(negedge clk);
            cyc++;
        end
        m0_valid = 0; m1_valid = 0;
        repeat (5) begin
            #1;
            if (m0_resp_valid) r0++;
            if (m1_resp_valid) r1++;
            @(negedge clk);
        end
        m0_resp_ready = 0; m1_resp_ready = 0;
        chk("tie_grant_count", 64'(n), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("tie_grant%0d", i), 64'(g[i]), 64'(i % 2));
        chk("tie_resp_m0", 64'(r0), 2);
        chk("tie_resp_m1", 64'(r1), 2);

        for (int i = 0; i < 11; i++) begin
            model(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d, rd, er, lat, wc, wd);
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Backpressure: held response, other port locked out
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 8'h0, CMP, 64'h0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 8'h0, CMP, 64'h0);
        set_req(1'b1, 1'b1, 1'b0, 8'h0, MT, 64'h0);
        k = 0;
        #1;
        while (!m0_resp_valid && k < 10) begin @(negedge clk); #1; k++; end
        chk("bp_resp_seen", 64'(m0_resp_valid), 1);
        repeat (5) begin
            @(negedge clk); #1;
            chk("bp_valid", 64'(m0_resp_valid), 1);
            chk("bp_rdata", m0_rdata, m_cmp);
            chk("bp_m1_ready", 64'(m1_ready), 0);
        end
        @(negedge clk);
        m1_valid = 0; m0_resp_ready = 1;
        @(negedge clk);
        m0_resp_ready = 0;
        #1 chk("bp_released", 64'(m0_resp_valid), 0);

        for (int i = 0; i < 40; i++) begin
            int sel;
            v.p = 1'($urandom_range(0, 1));
            v.w = 1'($urandom_range(0, 1));
            v.s = 8'($urandom);
            sel = $urandom_range(0, 3);
            v.a = sel < 2 ? CMP : sel == 2 ? MT : CMP + 32'($urandom_range(1, 7));
            v.d = {$urandom, $urandom};
            model(v.w, v.s, v.a, v.d, v.rd, v.er, v.lat, v.wc, v.wd);
            apply(v, $sformatf("rnd%0d", i));
        end

        // Reset during WRITE (wstrb = 0 so the register value is the same either way)
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b1, 8'h00, MT, 64'hFFFF);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b1, 8'h00, MT, 64'hFFFF);
        k = 0;
        #1;
        while (!clint_wen && k < 10) begin @(negedge clk); #1; k++; end
        chk("rw_in_write", 64'(clint_wen), 1);
        m0_valid = 1; m1_valid = 1;
        rst_n = 0;
        #1;
        chk("rw_ready", 64'({m0_ready, m1_ready}), 0);
        chk("rw_clint", {31'd0, clint_wen, clint_addr}, 0);
        chk("rw_clint_wdata", clint_wdata, 0);
        chk("rw_resp", 64'({m0_resp_valid, m1_resp_valid, m0_resp_err, m1_resp_err}), 0);
        chk("rw_rdata", m0_rdata | m1_rdata, 0);
        @(negedge clk);
        rst_n = 1;
        set_req(1'b0, 1'b1, 1'b0, 8'h0, CMP, 64'h0);
        set_req(1'b1, 1'b1, 1'b0, 8'h0, MT, 64'h0);
        #1;
        chk("rw_tie_m0", 64'(m0_ready), 1);
        chk("rw_tie_m1", 64'(m1_ready), 0);
        @(negedge clk);
        m0_valid = 0; m1_valid = 0; m0_resp_ready = 1; m1_resp_ready = 1;
        repeat (4) @(negedge clk);
        m0_resp_ready = 0; m1_resp_ready = 0;
        run(1'b0, 1'b0, 8'h0, MT, 64'h0, rd, er, lat, wc, wd, er);
        chk("rw_mtime_after", rd, m_time);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
